alu_mc: RTL and testbench

Registered, parametrised successor to the team's combinational ALU, with valid/ready handshakes and a zero/carry flag pair. It adds variable-amount shifts, subtract, arithmetic shift, signed compare, and an iterative multi-cycle multiply. It sits between the decode/operand-fetch stage and writeback of the datapath, and absorbs back-pressure from writeback.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_mc_if.sv | 25 ++
 rtl/alu_mul_iter.sv | 55 +++++
 rtl/alu_mc.sv | 121 ++++++++++++
 tb/tb_alu_mc.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encoding and multiplier latency for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_SUB  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_SLT  = 4'hB;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StHold = 2'd2
    } state_t;

    // One partial-product bit per cycle, so latency equals operand width.
    function automatic int unsigned mul_latency(input int unsigned width);
        return width;
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operation/result handshake bundle between operand fetch, the ALU and writeback.
interface alu_mc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             carry;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, zero, carry
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, zero, carry
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: low WIDTH bits of unsigned a*b, one multiplier bit per cycle.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(mul_latency(WIDTH) - 1);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    // product is the accumulator after the current step, so the final sum is
    // available on the same edge that completes the last iteration.
    assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Registered ALU with valid/ready handshakes, zero/carry flags and an iterative multiply.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    state_t           state;
    logic             out_valid_q;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic             carry_q;

    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             res_carry;

    // Only out_ready reaches in_ready combinationally; everything else is registered.
    assign bus.in_ready  = (state == StIdle) || ((state == StHold) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign mul_start     = accept && (bus.op == OP_MUL);

    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        shamt     = bus.b[SHW-1:0];
        sum       = {1'b0, bus.a} + {1'b0, bus.b};
        diff      = {1'b0, bus.a} - {1'b0, bus.b};
        res       = '0;
        res_carry = 1'b0;
        case (bus.op)
            OP_ADD: begin
                res       = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
            end
            OP_SUB: begin
                res       = diff[WIDTH-1:0];
                res_carry = diff[WIDTH];  // borrow out == unsigned a < b
            end
            OP_AND:  res = bus.a & bus.b;
            OP_OR:   res = bus.a | bus.b;
            OP_XOR:  res = bus.a ^ bus.b;
            OP_XNOR: res = ~(bus.a ^ bus.b);
            OP_SHL:  res = bus.a << shamt;
            OP_SHR:  res = bus.a >> shamt;
            OP_SRA:  res = $signed(bus.a) >>> shamt;
            OP_SLT:  res = {{(WIDTH - 1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
        end else if (accept) begin
            if (bus.op == OP_MUL) begin
                state       <= StMul;
                out_valid_q <= 1'b0;
            end else begin
                state       <= StHold;
                out_valid_q <= 1'b1;
                y_q         <= res;
                zero_q      <= (res == '0);
                carry_q     <= res_carry;
            end
        end else begin
            case (state)
                StMul: begin
                    if (mul_busy && mul_done) begin
                        state       <= StHold;
                        out_valid_q <= 1'b1;
                        y_q         <= mul_product;
                        zero_q      <= (mul_product == '0);
                        carry_q     <= 1'b0;
                    end
                end
                StHold: begin
                    if (bus.out_ready) begin
                        state       <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32.
module tb_alu_mc;
    localparam int unsigned W = 32;

    localparam logic [3:0] ADD  = 4'h1;
    localparam logic [3:0] AND_ = 4'h2;
    localparam logic [3:0] OR_  = 4'h3;
    localparam logic [3:0] XOR_ = 4'h4;
    localparam logic [3:0] SHL  = 4'h5;
    localparam logic [3:0] SHR  = 4'h6;
    localparam logic [3:0] XNOR_ = 4'h7;
    localparam logic [3:0] SUB  = 4'h8;
    localparam logic [3:0] SRA  = 4'h9;
    localparam logic [3:0] MUL  = 4'hA;
    localparam logic [3:0] SLT  = 4'hB;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one op while the DUT is known to be ready, return #1 after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.a        = x;
        bus.b        = z;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = 4'h0;
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] z, input logic [W-1:0] ey, input logic ez,
                          input logic ec);
        issue(o, x, z);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(1'b1));
        check({tag, "_y"}, 64'(bus.y), 64'(ey));
        check({tag, "_zero"}, 64'(bus.zero), 64'(ez));
        check({tag, "_carry"}, 64'(bus.carry), 64'(ec));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_drop"}, 64'(bus.out_valid), 64'(1'b0));
    endtask

    int          n;
    logic        flag;
    int          idx_in;
    int          idx_out;
    logic        acc;
    logic        held;
    logic [W-1:0] held_y;
    logic [W-1:0] exp_q [4];
    logic        pat [4];

    initial begin
        checks = 0;
        errors = 0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        bus.op        = ADD;
        bus.a         = 32'd1;
        bus.b         = 32'd1;
        rst           = 1'b1;

        // Reset held three cycles with a pending op: nothing may be captured.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_y", 64'(bus.y), 64'd0);
        check("rst_zero", 64'(bus.zero), 64'd0);
        check("rst_carry", 64'(bus.carry), 64'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        check("rst_no_emit", 64'(bus.out_valid), 64'd0);

        run_op("add_wrap", ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b1);
        run_op("sub_borrow", SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b1);
        run_op("sub_eq", SUB, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
        run_op("add_plain", ADD, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0);
        run_op("shl_mask", SHL, 32'h1, 32'h21, 32'h2, 1'b0, 1'b0);
        run_op("shl_zero", SHL, 32'h1234, 32'h20, 32'h1234, 1'b0, 1'b0);
        run_op("sra", SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0);
        run_op("shr", SHR, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0);
        run_op("and", AND_, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0);
        run_op("or", OR_, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 1'b0);
        run_op("xor", XOR_, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, 1'b0);
        run_op("xnor", XNOR_, 32'hF0F0, 32'hFF00, 32'hFFFF_F00F, 1'b0, 1'b0);
        run_op("slt_true", SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        run_op("slt_false", SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        run_op("op_f", 4'hF, 32'd7, 32'd9, 32'd0, 1'b1, 1'b0);
        run_op("op_0", 4'h0, 32'd7, 32'd9, 32'd0, 1'b1, 1'b0);

        // MUL: exactly 32 cycles, in_ready low throughout, operands changed after accept.
        issue(MUL, 32'h0001_0003, 32'h0000_0005);
        n    = 0;
        flag = 1'b0;
        while (!bus.out_valid && n < 100) begin
            if (bus.in_ready) flag = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        check("mul_latency", 64'(n), 64'd32);
        check("mul_in_ready_low", 64'(flag), 64'd0);
        check("mul_y", 64'(bus.y), 64'h0005_000F);
        check("mul_carry", 64'(bus.carry), 64'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        issue(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mul_max_latency", 64'(n), 64'd32);
        check("mul_max_y", 64'(bus.y), 64'h1);
        check("mul_max_zero", 64'(bus.zero), 64'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Back-pressure stream: out_ready pattern 1,0,0,1 repeating.
        exp_q[0] = 32'd11;
        exp_q[1] = 32'd22;
        exp_q[2] = 32'd33;
        exp_q[3] = 32'd44;
        pat[0] = 1'b1;
        pat[1] = 1'b0;
        pat[2] = 1'b0;
        pat[3] = 1'b1;
        idx_in  = 0;
        idx_out = 0;
        for (int c = 0; c < 40 && idx_out < 4; c++) begin
            bus.out_ready = pat[c % 4];
            bus.in_valid  = (idx_in < 4);
            bus.op        = ADD;
            bus.a         = 32'(10 * (idx_in + 1));
            bus.b         = 32'(idx_in + 1);
            #1;
            acc  = bus.in_valid && bus.in_ready;
            held = bus.out_valid && !bus.out_ready;
            held_y = bus.y;
            if (bus.out_valid && bus.out_ready) begin
                check("bp_order", 64'(bus.y), 64'(exp_q[idx_out]));
                idx_out++;
            end
            @(posedge clk);
            #1;
            if (acc) idx_in++;
            if (held) check("bp_stable", 64'(bus.y), 64'(held_y));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("bp_delivered", 64'(idx_out), 64'd4);
        check("bp_accepted", 64'(idx_in), 64'd4);
        check("bp_empty", 64'(bus.out_valid), 64'd0);

        // Full throughput with out_ready held high.
        bus.out_ready = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.op       = ADD;
            bus.a        = 32'(100 + i);
            bus.b        = 32'(i);
            #1;
            if (!bus.in_ready) flag = 1'b1;
            @(posedge clk);
            #1;
            check("tp_y", 64'(bus.y), 64'(100 + 2 * i));
            check("tp_valid", 64'(bus.out_valid), 64'd1);
        end
        check("tp_ready_high", 64'(flag), 64'd0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("tp_drain", 64'(bus.out_valid), 64'd0);

        // Abort a MUL at its tenth cycle; nothing may ever be emitted.
        issue(MUL, 32'd7, 32'd9);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_valid", 64'(bus.out_valid), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        flag = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) flag = 1'b1;
        end
        check("abort_no_emit", 64'(flag), 64'd0);
        run_op("post_abort_add", ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
